cp0_exception_unit: RTL and testbench
=====================================

// Module: cp0_exception_unit
// PURPOSE
//  Parametrised Coprocessor-0 for the MIPS core.
//  Holds Count, Compare, Status, Cause and EPC, and takes exceptions, interrupts and ERET.
//  Drives a registered PC-redirect to the fetch stage.
//  The core writes it through mtc0, reads it through mfc0, and sees one exception request port from the pipeline.
// PARAMETERS
//  DATA_W      32            register/data width (>=16)
//  NUM_HW_IRQ  5             external interrupt lines, mapped to Cause.IP[2+:NUM_HW_IRQ], max 5
//  EXC_VECTOR  32'h0000_0180 redirect target on exception/interrupt entry
//  RST_STATUS  32'h0000_0000 Status value after reset
// PORTS
//  clk         in   1        clock, rising edge
//  rst         in   1        reset, asynchronous, active-high
//  raddr       in   5        mfc0 register select
//  rdata       out  DATA_W   mfc0 read data, combinational
//  we          in   1        mtc0 write enable
//  waddr       in   5        mtc0 register select
//  wdata       in   DATA_W   mtc0 data
//  exc_req     in   1        synchronous exception from pipeline
//  exc_code    in   5        ExcCode for exc_req
//  exc_pc      in   DATA_W   faulting PC
//  exc_bd      in   1        faulting instruction is in a delay slot
//  eret        in   1        ERET retiring
//  int_ok      in   1        pipeline at an interruptible boundary
//  cur_pc      in   DATA_W   PC to save when an interrupt is taken
//  hw_irq      in   NUM_HW_IRQ  level-sensitive external interrupts
//  int_pending out  1        interrupt would be taken if int_ok
//  redirect    out  1        one-cycle pulse: flush and fetch from redirect_pc
//  redirect_pc out  DATA_W   target; valid while redirect=1
// BEHAVIOUR
//  - Register map: 9=Count, 11=Compare, 12=Status, 13=Cause, 14=EPC.
//    Other addresses read 0; writes to them are ignored.
//  - Status fields: [0]=IE, [1]=EXL, [15:8]=IM. Other bits read 0 and are not writable.
//  - Cause fields: [31]=BD, [15:8]=IP, [6:2]=ExcCode.
//    mtc0 to Cause writes only IP[1:0] (software interrupts).
//    IP[2+:NUM_HW_IRQ] mirror hw_irq every cycle. IP[7] is the timer flag. Unused IP bits read 0.
//  - Reset values:
//    - Count, Compare, Cause, EPC = 0; Status = RST_STATUS.
//    - redirect = 0, redirect_pc = 0.
//  - Count increments by 1 every cycle and wraps from all-ones to 0.
//    An mtc0 to Count that cycle loads wdata instead of incrementing.
//  - Timer: IP[7] sets in the cycle after Count==Compare and stays set until an mtc0 to Compare clears it.
//    If the match and the Compare write happen in the same cycle, the clear wins.
//  - int_pending = IE & ~EXL & |(IP & IM). It is combinational from registered state.
//    hw_irq affects it one cycle after it changes.
//  - Event priority each cycle, highest first: exc_req, interrupt (int_pending & int_ok), eret, mtc0.
//    A lower-priority event is dropped in a cycle where a higher one occurs.
//    An exception or interrupt blocks any mtc0 in the same cycle.
//  - Exception entry (exc_req=1):
//    - EPC <= exc_pc; Cause.BD <= exc_bd; Cause.ExcCode <= exc_code; Status.EXL <= 1.
//    - Next cycle: redirect=1, redirect_pc=EXC_VECTOR.
//    - exc_req while EXL=1 still updates EPC, BD and ExcCode (no nesting protection).
//  - Interrupt entry: same as exception entry, with ExcCode=0, EPC=cur_pc and BD=0.
//  - ERET: Status.EXL <= 0. Next cycle: redirect=1, redirect_pc = EPC value before this edge.
//    EPC must be captured before any same-cycle write.
//  - redirect is high for exactly one cycle per event. Back-to-back events give back-to-back pulses.
//  - mtc0 write becomes visible on rdata in the cycle after we. There is no write-to-read bypass.
//  - rst mid-operation: all state and outputs clear asynchronously.
//    A redirect pending at that moment is lost.
// STRUCTURE
//  - Shared package cp0_pkg:
//    - register address constants (CP0_COUNT..CP0_EPC);
//    - Status/Cause bit-position constants;
//    - ExcCode constants (INT=0, ADEL=4, SYS=8, BP=9, RI=10, OV=12).
//  - One sub-module, cp0_timer: the Count/Compare pair and the IP[7] flag, with a write port and an irq output.
//  - Everything else stays in the top level: event priority mux, Status/Cause/EPC, redirect register.
// TESTING
//  1. Reset, then read all map addresses -> Count small and increasing, Status=RST_STATUS, others 0, redirect=0.
//  2. mtc0 Compare=20, Count=10; IM[7]=1, IE=1 -> IP[7] set 11 cycles after the Count write.
//     int_ok=1 -> redirect pulse to 0x180, ExcCode=0, EPC=cur_pc, EXL=1.
//  3. exc_req code=12, exc_pc=0x400, exc_bd=1 -> next cycle redirect_pc=0x180;
//     EPC=0x400, BD=1, ExcCode=12.
//     Then eret -> redirect_pc=0x400, EXL=0.
//  4. exc_req and eret in the same cycle, with mtc0 Status -> only the exception takes effect;
//     Status write is dropped; one redirect to 0x180.
//  5. hw_irq[0]=1 with IM[2]=1 and EXL=1 -> int_pending=0.
//     After eret -> int_pending=1 one cycle later; taken only when int_ok=1.
//  6. Count=32'hFFFF_FFFF -> next cycle 0.
//     mtc0 Compare that cycle with Count==Compare -> IP[7] stays 0.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register map, Status/Cause field positions, ExcCodes.
package cp0_pkg;

  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_STATUS  = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;

  localparam int ST_IE         = 0;
  localparam int ST_EXL        = 1;
  localparam int ST_IM_LSB     = 8;
  localparam int CAUSE_BD      = 31;
  localparam int CAUSE_IP_LSB  = 8;
  localparam int CAUSE_EXC_LSB = 2;
  localparam int IP_HW_LSB     = 2;
  localparam int IP_TIMER      = 7;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_SYS  = 5'd8,
    EXC_BP   = 5'd9,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare pair with the sticky timer interrupt flag (Cause.IP[7]).
module cp0_timer #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we_count,
  input  logic              i_we_compare,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_count,
  output logic [DATA_W-1:0] o_compare,
  output logic              o_irq
);

  localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] r_count;
  logic [DATA_W-1:0] r_compare;
  logic              r_irq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count   <= '0;
      r_compare <= '0;
      r_irq     <= 1'b0;
    end else begin
      if (i_we_count) r_count <= i_wdata;
      else            r_count <= r_count + ONE;

      if (i_we_compare) r_compare <= i_wdata;

      // A Compare write acknowledges the timer and beats a same-cycle match.
      if (i_we_compare)               r_irq <= 1'b0;
      else if (r_count == r_compare)  r_irq <= 1'b1;
    end
  end

  assign o_count   = r_count;
  assign o_compare = r_compare;
  assign o_irq     = r_irq;

endmodule

// File: rtl/cp0_exception_unit.sv
// Coprocessor-0: Status/Cause/EPC, exception/interrupt/ERET sequencing and the
// registered PC redirect to fetch. Count/Compare live in cp0_timer.
module cp0_exception_unit
  import cp0_pkg::*;
#(
  parameter int                DATA_W     = 32,
  parameter int                NUM_HW_IRQ = 5,
  parameter logic [DATA_W-1:0] EXC_VECTOR = 'h180,
  parameter logic [DATA_W-1:0] RST_STATUS = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4:0]            i_raddr,
  output logic [DATA_W-1:0]     o_rdata,
  input  logic                  i_we,
  input  logic [4:0]            i_waddr,
  input  logic [DATA_W-1:0]     i_wdata,
  input  logic                  i_exc_req,
  input  logic [4:0]            i_exc_code,
  input  logic [DATA_W-1:0]     i_exc_pc,
  input  logic                  i_exc_bd,
  input  logic                  i_eret,
  input  logic                  i_int_ok,
  input  logic [DATA_W-1:0]     i_cur_pc,
  input  logic [NUM_HW_IRQ-1:0] i_hw_irq,
  output logic                  o_int_pending,
  output logic                  o_redirect,
  output logic [DATA_W-1:0]     o_redirect_pc
);

  // Narrow configurations fold BD onto the top data bit.
  localparam int BD_POS = (DATA_W > CAUSE_BD) ? CAUSE_BD : DATA_W - 1;

  logic                  r_ie;
  logic                  r_exl;
  logic [7:0]            r_im;
  logic                  r_bd;
  logic [1:0]            r_ip_sw;
  logic [NUM_HW_IRQ-1:0] r_ip_hw;
  logic [4:0]            r_exc_code;
  logic [DATA_W-1:0]     r_epc;
  logic                  r_redirect;
  logic [DATA_W-1:0]     r_redirect_pc;

  logic [DATA_W-1:0] w_count;
  logic [DATA_W-1:0] w_compare;
  logic              w_timer_irq;
  logic [7:0]        w_ip;
  logic              w_int_pending;
  logic              w_take_exc;
  logic              w_take_int;
  logic              w_take_eret;
  logic              w_take_mtc0;

  always_comb begin
    w_ip                           = '0;
    w_ip[1:0]                      = r_ip_sw;
    w_ip[IP_HW_LSB +: NUM_HW_IRQ]  = r_ip_hw;
    w_ip[IP_TIMER]                 = w_timer_irq;
  end

  assign w_int_pending = r_ie & ~r_exl & (|(w_ip & r_im));

  assign w_take_exc  = i_exc_req;
  assign w_take_int  = ~i_exc_req & w_int_pending & i_int_ok;
  assign w_take_eret = ~i_exc_req & ~w_take_int & i_eret;
  assign w_take_mtc0 = i_we & ~i_exc_req & ~w_take_int & ~w_take_eret;

  cp0_timer #(
    .DATA_W (DATA_W)
  ) u_timer (
    .clk          (clk),
    .rst          (rst),
    .i_we_count   (w_take_mtc0 && (i_waddr == CP0_COUNT)),
    .i_we_compare (w_take_mtc0 && (i_waddr == CP0_COMPARE)),
    .i_wdata      (i_wdata),
    .o_count      (w_count),
    .o_compare    (w_compare),
    .o_irq        (w_timer_irq)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ie          <= RST_STATUS[ST_IE];
      r_exl         <= RST_STATUS[ST_EXL];
      r_im          <= RST_STATUS[ST_IM_LSB +: 8];
      r_bd          <= 1'b0;
      r_ip_sw       <= '0;
      r_ip_hw       <= '0;
      r_exc_code    <= '0;
      r_epc         <= '0;
      r_redirect    <= 1'b0;
      r_redirect_pc <= '0;
    end else begin
      r_ip_hw    <= i_hw_irq;
      r_redirect <= w_take_exc | w_take_int | w_take_eret;

      if (w_take_exc) begin
        r_epc         <= i_exc_pc;
        r_bd          <= i_exc_bd;
        r_exc_code    <= i_exc_code;
        r_exl         <= 1'b1;
        r_redirect_pc <= EXC_VECTOR;
      end else if (w_take_int) begin
        r_epc         <= i_cur_pc;
        r_bd          <= 1'b0;
        r_exc_code    <= EXC_INT;
        r_exl         <= 1'b1;
        r_redirect_pc <= EXC_VECTOR;
      end else if (w_take_eret) begin
        r_exl         <= 1'b0;
        r_redirect_pc <= r_epc;
      end else if (w_take_mtc0) begin
        case (i_waddr)
          CP0_STATUS: begin
            r_ie  <= i_wdata[ST_IE];
            r_exl <= i_wdata[ST_EXL];
            r_im  <= i_wdata[ST_IM_LSB +: 8];
          end
          CP0_CAUSE: r_ip_sw <= i_wdata[CAUSE_IP_LSB +: 2];
          CP0_EPC:   r_epc   <= i_wdata;
          default:   ;
        endcase
      end
    end
  end

  always_comb begin
    o_rdata = '0;
    case (i_raddr)
      CP0_COUNT:   o_rdata = w_count;
      CP0_COMPARE: o_rdata = w_compare;
      CP0_STATUS: begin
        o_rdata[ST_IE]               = r_ie;
        o_rdata[ST_EXL]              = r_exl;
        o_rdata[ST_IM_LSB +: 8]      = r_im;
      end
      CP0_CAUSE: begin
        o_rdata[BD_POS]              = r_bd;
        o_rdata[CAUSE_IP_LSB +: 8]   = w_ip;
        o_rdata[CAUSE_EXC_LSB +: 5]  = r_exc_code;
      end
      CP0_EPC:     o_rdata = r_epc;
      default:     o_rdata = '0;
    endcase
  end

  assign o_int_pending = w_int_pending;
  assign o_redirect    = r_redirect;
  assign o_redirect_pc = r_redirect_pc;

endmodule

// File: tb/tb_cp0_exception_unit.sv
// Directed bench for cp0_exception_unit: hand-computed register/redirect values.
module tb_cp0_exception_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  i_raddr = '0;
  logic [31:0] o_rdata;
  logic        i_we = 1'b0;
  logic [4:0]  i_waddr = '0;
  logic [31:0] i_wdata = '0;
  logic        i_exc_req = 1'b0;
  logic [4:0]  i_exc_code = '0;
  logic [31:0] i_exc_pc = '0;
  logic        i_exc_bd = 1'b0;
  logic        i_eret = 1'b0;
  logic        i_int_ok = 1'b0;
  logic [31:0] i_cur_pc = '0;
  logic [4:0]  i_hw_irq = '0;
  logic        o_int_pending;
  logic        o_redirect;
  logic [31:0] o_redirect_pc;

  int checks = 0;
  int failures = 0;

  cp0_exception_unit #(
    .DATA_W     (32),
    .NUM_HW_IRQ (5),
    .EXC_VECTOR (32'h0000_0180),
    .RST_STATUS (32'h8000_0402)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_raddr       (i_raddr),
    .o_rdata       (o_rdata),
    .i_we          (i_we),
    .i_waddr       (i_waddr),
    .i_wdata       (i_wdata),
    .i_exc_req     (i_exc_req),
    .i_exc_code    (i_exc_code),
    .i_exc_pc      (i_exc_pc),
    .i_exc_bd      (i_exc_bd),
    .i_eret        (i_eret),
    .i_int_ok      (i_int_ok),
    .i_cur_pc      (i_cur_pc),
    .i_hw_irq      (i_hw_irq),
    .o_int_pending (o_int_pending),
    .o_redirect    (o_redirect),
    .o_redirect_pc (o_redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-16s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
    i_raddr = a;
    #1;
    chk(tag, o_rdata, exp);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    i_we = 1'b1; i_waddr = a; i_wdata = d;
    step();
    i_we = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1. reset values
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    rd("rst_count0", 5'd9, 32'd0);
    rd("rst_compare", 5'd11, 32'd0);
    rd("rst_status", 5'd12, 32'h0000_0402);
    rd("rst_cause", 5'd13, 32'd0);
    chk("rst_redirect", {31'd0, o_redirect}, 32'd0);
    step();
    rd("rst_count1", 5'd9, 32'd1);
    rd("rst_epc", 5'd14, 32'd0);
    rd("unmapped", 5'd5, 32'd0);
    chk("rst_intpend", {31'd0, o_int_pending}, 32'd0);

    // 2. timer interrupt
    wr(5'd11, 32'd20);
    wr(5'd12, 32'h0000_8001);
    wr(5'd9, 32'd10);
    rd("cnt_loaded", 5'd9, 32'd10);
    rd("status_wr", 5'd12, 32'h0000_8001);
    for (int k = 0; k < 10; k++) step();
    rd("cnt_at_match", 5'd9, 32'd20);
    rd("ip7_not_yet", 5'd13, 32'd0);
    step();
    rd("ip7_set", 5'd13, 32'h0000_8000);
    chk("tmr_intpend", {31'd0, o_int_pending}, 32'd1);
    chk("no_take_intok0", {31'd0, o_redirect}, 32'd0);
    i_int_ok = 1'b1; i_cur_pc = 32'h0000_1234;
    step();
    i_int_ok = 1'b0;
    chk("int_redirect", {31'd0, o_redirect}, 32'd1);
    chk("int_redir_pc", o_redirect_pc, 32'h0000_0180);
    rd("int_epc", 5'd14, 32'h0000_1234);
    rd("int_status", 5'd12, 32'h0000_8003);
    rd("int_cause", 5'd13, 32'h0000_8000);
    wr(5'd11, 32'hFFFF_0000);
    chk("int_pulse_end", {31'd0, o_redirect}, 32'd0);
    rd("ip7_cleared", 5'd13, 32'd0);

    // 3. exception then ERET, back-to-back pulses
    i_exc_req = 1'b1; i_exc_code = 5'd12; i_exc_pc = 32'h0000_0400; i_exc_bd = 1'b1;
    step();
    i_exc_req = 1'b0; i_exc_bd = 1'b0;
    chk("exc_redirect", {31'd0, o_redirect}, 32'd1);
    chk("exc_redir_pc", o_redirect_pc, 32'h0000_0180);
    rd("exc_epc", 5'd14, 32'h0000_0400);
    rd("exc_cause", 5'd13, 32'h8000_0030);
    i_eret = 1'b1;
    step();
    i_eret = 1'b0;
    chk("eret_redirect", {31'd0, o_redirect}, 32'd1);
    chk("eret_redir_pc", o_redirect_pc, 32'h0000_0400);
    rd("eret_status", 5'd12, 32'h0000_8001);
    step();
    chk("eret_pulse_end", {31'd0, o_redirect}, 32'd0);

    // 4. exc + eret + mtc0 Status in one cycle
    i_exc_req = 1'b1; i_exc_code = 5'd8; i_exc_pc = 32'h0000_0500;
    i_eret = 1'b1;
    i_we = 1'b1; i_waddr = 5'd12; i_wdata = 32'd0;
    step();
    i_exc_req = 1'b0; i_eret = 1'b0; i_we = 1'b0;
    chk("prio_redir_pc", o_redirect_pc, 32'h0000_0180);
    rd("prio_status", 5'd12, 32'h0000_8003);
    rd("prio_epc", 5'd14, 32'h0000_0500);
    rd("prio_cause", 5'd13, 32'h0000_0020);
    step();
    chk("prio_one_pulse", {31'd0, o_redirect}, 32'd0);

    // 5. hw_irq masked by EXL, then taken after ERET when int_ok
    i_hw_irq = 5'b00001;
    wr(5'd12, 32'h0000_0403);
    step();
    chk("hw_exl_block", {31'd0, o_int_pending}, 32'd0);
    rd("hw_cause", 5'd13, 32'h0000_0420);
    i_eret = 1'b1;
    step();
    i_eret = 1'b0;
    chk("hw_eret_pc", o_redirect_pc, 32'h0000_0500);
    chk("hw_pend_after", {31'd0, o_int_pending}, 32'd1);
    step();
    chk("hw_wait_intok", {31'd0, o_redirect}, 32'd0);
    i_int_ok = 1'b1; i_cur_pc = 32'h0000_0600;
    step();
    i_int_ok = 1'b0; i_hw_irq = 5'b00000;
    chk("hw_taken", {31'd0, o_redirect}, 32'd1);
    rd("hw_epc", 5'd14, 32'h0000_0600);
    rd("hw_status", 5'd12, 32'h0000_0403);
    rd("hw_cause_int", 5'd13, 32'h0000_0400);
    step();
    rd("hw_cleared", 5'd13, 32'd0);

    // 6. Count wrap and match-vs-Compare-write race
    wr(5'd9, 32'hFFFF_FFFF);
    rd("cnt_max", 5'd9, 32'hFFFF_FFFF);
    step();
    rd("cnt_wrap", 5'd9, 32'd0);
    wr(5'd11, 32'd3);
    step();
    step();
    rd("cnt_eq_cmp", 5'd9, 32'd3);
    wr(5'd11, 32'd3);
    rd("race_ip7", 5'd13, 32'd0);
    step();
    rd("race_ip7_late", 5'd13, 32'd0);

    // asynchronous reset drops a pending redirect
    i_exc_req = 1'b1; i_exc_code = 5'd4; i_exc_pc = 32'h0000_0700;
    step();
    i_exc_req = 1'b0;
    chk("pre_rst_redir", {31'd0, o_redirect}, 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_redirect", {31'd0, o_redirect}, 32'd0);
    chk("arst_redir_pc", o_redirect_pc, 32'd0);
    rd("arst_epc", 5'd14, 32'd0);
    rd("arst_status", 5'd12, 32'h0000_0402);
    rst = 1'b0;
    step();
    chk("post_rst_redir", {31'd0, o_redirect}, 32'd0);
    rd("post_rst_count", 5'd9, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
